// File: rtl/load_unit.sv
// Load unit: fetches one 32-bit word from data memory and extracts a word, half or byte,
// sign- or zero-extended, with alignment checking and a single-cycle done/misalign pulse.
module load_unit #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        LOADwhb,
  input  logic              LOADsign,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_dout,
  output logic [31:0]       dout,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  typedef enum logic [2:0] {IDLE, READ, ALIGN, DONE, ERR} state_t;

  state_t      state, state_next;
  logic [1:0]  addr_lo;
  logic [1:0]  whb_q;
  logic        sign_q;
  logic [31:0] raw_q;
  logic        accept;
  logic        is_misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extracted;

  // Byte loads can never be misaligned; 2'b11 behaves as a word load.
  always_comb begin
    is_misaligned = 1'b0;
    case (LOADwhb)
      2'b01:   is_misaligned = address[0];
      2'b10:   is_misaligned = 1'b0;
      default: is_misaligned = (address[1:0] != 2'b00);
    endcase
  end

  assign accept = (state == IDLE) && start;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = is_misaligned ? ERR : READ;
      READ:    state_next = ALIGN;
      ALIGN:   state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign mem_rd   = (state == READ);
  assign done     = (state == DONE) || (state == ERR);
  assign misalign = (state == ERR);

  always_comb begin
    byte_sel = raw_q[7:0];
    case (addr_lo)
      2'd0: byte_sel = raw_q[7:0];
      2'd1: byte_sel = raw_q[15:8];
      2'd2: byte_sel = raw_q[23:16];
      2'd3: byte_sel = raw_q[31:24];
      default: byte_sel = raw_q[7:0];
    endcase
    half_sel = addr_lo[1] ? raw_q[31:16] : raw_q[15:0];
    case (whb_q)
      2'b01:   extracted = {{16{sign_q & half_sel[15]}}, half_sel};
      2'b10:   extracted = {{24{sign_q & byte_sel[7]}}, byte_sel};
      default: extracted = raw_q;
    endcase
  end

  // Request fields are captured only on acceptance so later input changes cannot disturb a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_lo  <= 2'b00;
      whb_q    <= 2'b00;
      sign_q   <= 1'b0;
      raw_q    <= 32'h0;
      mem_addr <= '0;
      dout     <= 32'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_lo <= address[1:0];
        whb_q   <= LOADwhb;
        sign_q  <= LOADsign;
        if (!is_misaligned) mem_addr <= {address[ADDR_W-1:2], 2'b00};
      end
      if (state == READ)  raw_q <= mem_dout;
      if (state == ALIGN) dout  <= extracted;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: memory model, reference extraction model and
// an expected-result queue popped whenever the unit signals done.
module tb_load_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  address;
  logic [1:0]  LOADwhb;
  logic        LOADsign;
  logic        mem_rd;
  logic [8:0]  mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] dout;
  logic        busy;
  logic        done;
  logic        misalign;

  logic [31:0] mem [0:511];
  logic [31:0] exp_q [$];
  bit          mis_q [$];
  logic [31:0] last_dout;
  int          n_checks;
  int          n_fail;

  load_unit #(.ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .address(address), .LOADwhb(LOADwhb),
    .LOADsign(LOADsign), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .dout(dout), .busy(busy), .done(done), .misalign(misalign)
  );

  assign mem_dout = mem[mem_addr];

  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [8:0] a,
                                             input logic [1:0] whb, input logic sgn);
    logic [31:0] r;
    if (whb == 2'b10) begin
      r = (w >> (a[1:0] * 8)) & 32'h0000_00FF;
      if (sgn && r[7]) r = r | 32'hFFFF_FF00;
    end else if (whb == 2'b01) begin
      r = a[1] ? (w >> 16) : (w & 32'h0000_FFFF);
      if (sgn && r[15]) r = r | 32'hFFFF_0000;
    end else begin
      r = w;
    end
    return r;
  endfunction

  function automatic bit model_mis(input logic [8:0] a, input logic [1:0] whb);
    if (whb == 2'b10) return 1'b0;
    if (whb == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  // One complete load: push expectation, pulse start, scramble inputs while busy, then check.
  task automatic do_load(input logic [8:0] a, input logic [1:0] whb, input logic sgn, input string name);
    bit mis;
    logic [31:0] expd;
    logic [31:0] got_d;
    bit got_m;
    int lat;
    int rd_count;
    mis  = model_mis(a, whb);
    expd = mis ? last_dout : model_load(mem[a & 9'h1FC], a, whb, sgn);
    exp_q.push_back(expd);
    mis_q.push_back(mis);
    address = a; LOADwhb = whb; LOADsign = sgn; start = 1'b1;
    lat = 0; rd_count = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        address = 9'($urandom); LOADwhb = 2'($urandom); LOADsign = 1'($urandom);
      end
      if (mem_rd) begin
        rd_count++;
        n_checks++;
        if (mem_addr !== {a[8:2], 2'b00}) begin
          n_fail++; $display("[TB] FAIL %s mem_addr: got %h expected %h", name, mem_addr, {a[8:2], 2'b00});
        end
      end
      if (done) begin lat = c; break; end
    end
    n_checks++;
    if (lat !== (mis ? 1 : 3)) begin
      n_fail++; $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, mis ? 1 : 3);
    end
    n_checks++;
    if (rd_count !== (mis ? 0 : 1)) begin
      n_fail++; $display("[TB] FAIL %s mem_rd cycles: got %0d expected %0d", name, rd_count, mis ? 0 : 1);
    end
    got_d = exp_q.pop_front();
    got_m = mis_q.pop_front();
    if (lat != 0) begin
      n_checks++;
      if (dout !== got_d) begin
        n_fail++; $display("[TB] FAIL %s dout: got %h expected %h", name, dout, got_d);
      end
      n_checks++;
      if (misalign !== got_m) begin
        n_fail++; $display("[TB] FAIL %s misalign: got %b expected %b", name, misalign, got_m);
      end
    end
    if (!mis) last_dout = expd;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, misalign} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL %s post-done busy/done/misalign: got %b expected 000", name, {busy, done, misalign});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; address = 9'h010; LOADwhb = 2'b00; LOADsign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, misalign, mem_rd} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset flags: got %b expected 0000", {busy, done, misalign, mem_rd});
    end
    n_checks++;
    if (dout !== 32'h0 || mem_addr !== 9'h0) begin
      n_fail++; $display("[TB] FAIL reset regs: got dout=%h mem_addr=%h expected 0/0", dout, mem_addr);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset start discarded: got busy=%b expected 0", busy);
    end
    last_dout = 32'h0;
  endtask

  task automatic test_word();
    do_load(9'h010, 2'b00, 1'b1, "lw");
    do_load(9'h014, 2'b11, 1'b0, "lw_11");
  endtask

  task automatic test_byte();
    do_load(9'h010, 2'b10, 1'b1, "lb_s0");
    do_load(9'h010, 2'b10, 1'b0, "lbu_0");
    do_load(9'h011, 2'b10, 1'b1, "lb_s1");
    do_load(9'h013, 2'b10, 1'b1, "lb_s3");
  endtask

  task automatic test_half();
    do_load(9'h012, 2'b01, 1'b1, "lh_s2");
    do_load(9'h012, 2'b01, 1'b0, "lhu_2");
    do_load(9'h010, 2'b01, 1'b1, "lh_s0");
  endtask

  task automatic test_misalign();
    do_load(9'h012, 2'b00, 1'b0, "lw_mis");
    do_load(9'h011, 2'b01, 1'b1, "lh_mis");
  endtask

  // start held high: only every fourth cycle is an acceptance; the rest carry decoy requests.
  task automatic test_back_to_back();
    logic [8:0] la [4] = '{9'h015, 9'h016, 9'h010, 9'h013};
    logic [1:0] lw [4] = '{2'b10, 2'b01, 2'b00, 2'b10};
    logic       ls [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] e;
    int dones;
    dones = 0;
    start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) begin
        address = la[k/4]; LOADwhb = lw[k/4]; LOADsign = ls[k/4];
        exp_q.push_back(model_load(mem[la[k/4] & 9'h1FC], la[k/4], lw[k/4], ls[k/4]));
      end else begin
        address = 9'h013; LOADwhb = 2'b00; LOADsign = 1'b1;
      end
      @(posedge clk); #1;
      if (done) begin
        dones++;
        n_checks++;
        if ((k % 4) !== 2) begin
          n_fail++; $display("[TB] FAIL b2b done timing: got done at cycle %0d expected cycle%%4==2", k);
        end
        n_checks++;
        if (misalign !== 1'b0) begin
          n_fail++; $display("[TB] FAIL b2b misalign: got %b expected 0", misalign);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (dout !== e) begin
          n_fail++; $display("[TB] FAIL b2b dout: got %h expected %h", dout, e);
        end
        last_dout = e;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (dones !== 4) begin
      n_fail++; $display("[TB] FAIL b2b done count: got %0d expected 4", dones);
    end
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL b2b final: got busy=%b pending=%0d expected 0/0", busy, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    int pulses;
    address = 9'h010; LOADwhb = 2'b00; LOADsign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1 || mem_rd !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort in ALIGN: got busy=%b mem_rd=%b expected 1/0", busy, mem_rd);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || dout !== 32'h0 || done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort state: got busy=%b dout=%h done=%b expected 0/0/0", busy, dout, done);
    end
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done || misalign) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("[TB] FAIL abort pulses: got %0d expected 0", pulses);
    end
    last_dout = 32'h0;
    do_load(9'h014, 2'b10, 1'b1, "after_abort");
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; start = 1'b0; address = '0; LOADwhb = '0; LOADsign = 1'b0;
    n_checks = 0; n_fail = 0; last_dout = 32'h0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h010] = 32'h8765_43A1;
    mem[9'h014] = 32'h1234_F0E8;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
